// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter that time-shares the four_digit_sseg `num` input among four requesters.
// Optional idle scroller enabled by defining SSEG_ARB_IDLE_SCROLL_EN.
module sseg_display_arbiter #(
  parameter int TICK_DIV    = 100000,
  parameter int DWELL_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] data,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [15:0] num,
  output logic [1:0]  owner,
  output logic        active
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      gnt_nxt, done_nxt;
  logic [15:0]     num_nxt;
  logic [1:0]      owner_nxt, ptr, ptr_nxt;
  logic            active_nxt;
  logic [PW-1:0]   pre, pre_nxt, pre_inc;
  logic [DW-1:0]   dwell, dwell_nxt, dwell_inc;
  logic [1:0]      sel, idx;
  logic            found, tick, expire;
  logic [3:0]      others;

  // First set request bit scanning upward from ptr+1; ptr itself is scanned last.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign tick      = (pre == PRE_MAX);
  assign expire    = tick && (dwell == DWELL_MAX);
  assign pre_inc   = tick ? '0 : pre + 1'b1;
  assign dwell_inc = tick ? dwell + 1'b1 : dwell;
  assign others    = req & ~(4'b0001 << owner);

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    num_nxt    = num;
    owner_nxt  = owner;
    active_nxt = active;
    ptr_nxt    = ptr;
    pre_nxt    = pre;
    dwell_nxt  = dwell;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nxt  = SHOW;
          gnt_nxt    = 4'b0001 << sel;
          owner_nxt  = sel;
          active_nxt = 1'b1;
          num_nxt    = data[{sel, 4'b0000} +: 16];
          pre_nxt    = '0;
          dwell_nxt  = '0;
        end
`ifdef SSEG_ARB_IDLE_SCROLL_EN
        else if (expire) begin
          owner_nxt = owner + 2'd1;
          num_nxt   = data[{owner_nxt, 4'b0000} +: 16];
          pre_nxt   = '0;
          dwell_nxt = '0;
        end else begin
          pre_nxt   = pre_inc;
          dwell_nxt = dwell_inc;
        end
`endif
      end
      SHOW: begin
        if (req[owner]) num_nxt = data[{owner, 4'b0000} +: 16];
        if (expire) begin
          pre_nxt   = '0;
          dwell_nxt = '0;
          // Renew only when the owner is the sole requester; otherwise hand over.
          if (!(req[owner] && others == 4'b0000)) begin
            state_nxt  = RELEASE;
            gnt_nxt    = '0;
            done_nxt   = gnt;
            active_nxt = 1'b0;
            ptr_nxt    = owner;
          end
        end else begin
          pre_nxt   = pre_inc;
          dwell_nxt = dwell_inc;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        pre_nxt   = '0;
        dwell_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      num    <= '0;
      owner  <= '0;
      active <= 1'b0;
      ptr    <= 2'd3;
      pre    <= '0;
      dwell  <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      num    <= num_nxt;
      owner  <= owner_nxt;
      active <= active_nxt;
      ptr    <= ptr_nxt;
      pre    <= pre_nxt;
      dwell  <= dwell_nxt;
    end
  end
endmodule
